// File: rtl/boss_ctrl.sv
// Two-phase boss controller: bounce motion, bullet hit detection, HP, invulnerability and death sequence.
// Optional build macro BOSS_FLASH_EN blinks the sprite while invulnerable or dying.
module boss_ctrl #(
    parameter int X_INIT        = 600,
    parameter int Y_INIT        = 40,
    parameter int X_SIZE        = 45,
    parameter int Y_SIZE        = 60,
    parameter int Y_MIN         = 4,
    parameter int Y_MAX         = 400,
    parameter int STEP_P1       = 3,
    parameter int STEP_P2       = 5,
    parameter int HP_MAX        = 200,
    parameter int HP_W          = 9,
    parameter int ENRAGE_HP     = 100,
    parameter int INVULN_FRAMES = 8,
    parameter int DEATH_FRAMES  = 60,
    parameter int ACTIVE_STATE  = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_clk,
    input  logic            key_R,
    input  logic            is_bullet,
    input  logic [3:0]      state_index,
    input  logic [9:0]      DrawX,
    input  logic [9:0]      DrawY,
    output logic [9:0]      boss_X_Addr,
    output logic [9:0]      boss_Y_Addr,
    output logic            is_boss,
    output logic [HP_W-1:0] boss_hp,
    output logic [2:0]      boss_phase,
    output logic            hit_pulse,
    output logic            boss_dead
);
    localparam int IW = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam int DW = (DEATH_FRAMES < 8) ? 3 : $clog2(DEATH_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PHASE1 = 3'd1,
        PHASE2 = 3'd2,
        DYING  = 3'd3,
        DEAD   = 3'd4
    } state_t;

    state_t          state;
    logic [9:0]      boss_y;
    logic            dir_up;
    logic [IW-1:0]   inv_cnt;
    logic [DW-1:0]   death_cnt;
    logic            shoot;
    logic            ovl_seen;
    logic            fr_q1, fr_q2, fr_tick;
    logic            active, live, in_win, overlap, hit_ok, blink;
    logic [10:0]     step, y_down_edge;
    logic [9:0]      y_nxt;
    logic            up_nxt;

    assign boss_phase  = state;
    assign fr_tick     = fr_q1 & ~fr_q2;
    assign active      = (state_index == 4'(ACTIVE_STATE));
    assign live        = (state == PHASE1) || (state == PHASE2);
    assign boss_X_Addr = DrawX - 10'(X_INIT);
    assign boss_Y_Addr = DrawY - boss_y;
    assign in_win      = (boss_X_Addr <= 10'(X_SIZE)) && (boss_Y_Addr <= 10'(Y_SIZE));
    assign overlap     = in_win & is_bullet;
    assign hit_ok      = overlap & ~shoot & (inv_cnt == '0) & live;

`ifdef BOSS_FLASH_EN
    assign blink = ((inv_cnt != '0) && inv_cnt[0]) || ((state == DYING) && death_cnt[2]);
`else
    assign blink = 1'b0;
`endif

    assign is_boss = in_win && (live || (state == DYING)) && !blink;

    // Bounce with clamping at both limits; 11-bit sums keep the bottom test from wrapping.
    always_comb begin
        step        = (state == PHASE2) ? 11'(STEP_P2) : 11'(STEP_P1);
        y_down_edge = {1'b0, boss_y} + 11'(Y_SIZE) + step;
        y_nxt       = boss_y;
        up_nxt      = dir_up;
        if (dir_up) begin
            if ({1'b0, boss_y} <= 11'(Y_MIN) + step) begin
                y_nxt  = 10'(Y_MIN);
                up_nxt = 1'b0;
            end else begin
                y_nxt = boss_y - step[9:0];
            end
        end else if (y_down_edge >= 11'(Y_MAX)) begin
            y_nxt  = 10'(Y_MAX - Y_SIZE);
            up_nxt = 1'b1;
        end else begin
            y_nxt = boss_y + step[9:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fr_q1 <= 1'b0;
            fr_q2 <= 1'b0;
        end else begin
            fr_q1 <= frame_clk;
            fr_q2 <= fr_q1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            boss_y    <= 10'(Y_INIT);
            dir_up    <= 1'b0;
            boss_hp   <= HP_W'(HP_MAX);
            inv_cnt   <= '0;
            death_cnt <= '0;
            shoot     <= 1'b0;
            ovl_seen  <= 1'b0;
            hit_pulse <= 1'b0;
            boss_dead <= 1'b0;
        end else if (key_R) begin
            state     <= IDLE;
            boss_y    <= 10'(Y_INIT);
            dir_up    <= 1'b0;
            boss_hp   <= HP_W'(HP_MAX);
            inv_cnt   <= '0;
            death_cnt <= '0;
            shoot     <= 1'b0;
            ovl_seen  <= 1'b0;
            hit_pulse <= 1'b0;
            boss_dead <= 1'b0;
        end else begin
            hit_pulse <= hit_ok;
            ovl_seen  <= fr_tick ? 1'b0 : (ovl_seen | overlap);
            if (hit_ok) begin
                boss_hp <= (boss_hp == '0) ? '0 : boss_hp - 1'b1;
                shoot   <= 1'b1;
                inv_cnt <= IW'(INVULN_FRAMES);
            end else if (fr_tick) begin
                // The latch only releases after a whole frame without any bullet overlap.
                if (!ovl_seen && !overlap) shoot <= 1'b0;
                if (inv_cnt != '0) inv_cnt <= inv_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (active) state <= PHASE1;
                end
                PHASE1, PHASE2: begin
                    if (fr_tick) begin
                        boss_y <= y_nxt;
                        dir_up <= up_nxt;
                    end
                    if (!active)
                        state <= IDLE;
                    else if (boss_hp == '0)
                        state <= DYING;
                    else if ((state == PHASE1) && (boss_hp <= HP_W'(ENRAGE_HP)))
                        state <= PHASE2;
                end
                DYING: begin
                    if (fr_tick) begin
                        if (death_cnt == DW'(DEATH_FRAMES - 1)) begin
                            state     <= DEAD;
                            boss_dead <= 1'b1;
                        end else begin
                            death_cnt <= death_cnt + 1'b1;
                        end
                    end
                end
                DEAD: begin
                    boss_dead <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boss_ctrl.sv
// Bench for boss_ctrl: directed frames and hits, hit pulses scored against an expected-HP queue.
module tb_boss_ctrl;
    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic       key_R;
    logic       is_bullet;
    logic [3:0] state_index;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] boss_X_Addr;
    logic [9:0] boss_Y_Addr;
    logic       is_boss;
    logic [8:0] boss_hp;
    logic [2:0] boss_phase;
    logic       hit_pulse;
    logic       boss_dead;

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];

    int exp_hp    = 200;
    int exp_phase = 0;
    int y_model   = 40;
    bit up_model  = 1'b0;
    int y_min_obs = 1023;
    int y_max_obs = 0;

    boss_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .key_R       (key_R),
        .is_bullet   (is_bullet),
        .state_index (state_index),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .boss_X_Addr (boss_X_Addr),
        .boss_Y_Addr (boss_Y_Addr),
        .is_boss     (is_boss),
        .boss_hp     (boss_hp),
        .boss_phase  (boss_phase),
        .hit_pulse   (hit_pulse),
        .boss_dead   (boss_dead)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int actual_y();
        logic [9:0] y;
        y = DrawY - boss_Y_Addr;
        return int'(y);
    endfunction

    // monitor: every hit pulse must match the next expected HP
    always @(negedge Clk) begin
        if (Reset_n && hit_pulse) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_hit actual_hp=%0d required=no_pulse", boss_hp);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if (boss_hp != e) begin
                    fails++;
                    $display("FAIL hit_hp actual=%0d required=%0d", boss_hp, e);
                end
            end
        end
    end

    task automatic tick();
        int step;
        int ya;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        if (exp_phase == 1 || exp_phase == 2) begin
            step = (exp_phase == 2) ? 5 : 3;
            if (up_model) begin
                if (y_model <= 4 + step) begin
                    y_model  = 4;
                    up_model = 1'b0;
                end else begin
                    y_model -= step;
                end
            end else if (y_model + 60 + step >= 400) begin
                y_model  = 340;
                up_model = 1'b1;
            end else begin
                y_model += step;
            end
        end
        ya = actual_y();
        check("boss_y", ya, y_model);
        if (ya < y_min_obs) y_min_obs = ya;
        if (ya > y_max_obs) y_max_obs = ya;
    endtask

    task automatic hit(input int ncyc, input bit accept);
        @(negedge Clk);
        DrawX     = 10'd610;
        DrawY     = 10'(y_model + 10);
        is_bullet = 1'b1;
        if (accept) begin
            exp_hp--;
            exp_q.push_back(9'(exp_hp));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (i == ncyc - 1) is_bullet = 1'b0;
            if (accept && exp_hp == 100 && i == 0) check("phase_before_enrage", int'(boss_phase), 1);
            if (accept && exp_hp == 100 && i == 1) check("phase_enraged", int'(boss_phase), 2);
            if (accept && exp_hp == 0 && i == 1) check("phase_dying", int'(boss_phase), 3);
        end
        check("missing_hit_pulse", exp_q.size(), 0);
        exp_q.delete();
        if (accept && exp_hp == 100) exp_phase = 2;
        if (accept && exp_hp == 0) exp_phase = 3;
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    task automatic probe(input int dx, input int dy, input int exp, input string name);
        @(negedge Clk);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        #1;
        check(name, int'(is_boss), exp);
        DrawX = 10'd0;
        DrawY = 10'd0;
    endtask

    initial begin
        Reset_n     = 1'b0;
        frame_clk   = 1'b0;
        key_R       = 1'b0;
        is_bullet   = 1'b0;
        state_index = 4'd2;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        repeat (3) @(negedge Clk);
        check("reset_hp", int'(boss_hp), 200);
        check("reset_phase", int'(boss_phase), 0);
        check("reset_hit_pulse", int'(hit_pulse), 0);
        check("reset_dead", int'(boss_dead), 0);
        check("reset_y", actual_y(), 40);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("start_phase1", int'(boss_phase), 1);
        exp_phase = 1;
        tick();

        // sprite window edges
        probe(610, y_model + 10, 1, "win_inside");
        probe(599, y_model + 10, 0, "win_left_wrap");
        probe(645, y_model + 10, 1, "win_right_edge");
        probe(646, y_model + 10, 0, "win_right_out");
        probe(610, y_model + 60, 1, "win_bottom_edge");
        probe(610, y_model + 61, 0, "win_bottom_out");
        probe(610, y_model - 1, 0, "win_top_wrap");

        // bounce across both limits
        repeat (220) tick();
        check("bounce_max", y_max_obs, 340);
        check("bounce_min", y_min_obs, 4);

        // leaving the active game state freezes and hides the boss
        @(negedge Clk);
        state_index = 4'd0;
        @(negedge Clk);
        check("idle_phase", int'(boss_phase), 0);
        check("idle_hp", int'(boss_hp), 200);
        probe(610, y_model + 10, 0, "idle_hidden");
        state_index = 4'd2;
        @(negedge Clk);
        check("resume_phase", int'(boss_phase), 1);
        check("resume_y", actual_y(), y_model);

        // held bullet gives one hit; invulnerability blocks the next frame
        hit(3, 1'b1);
        tick();
        hit(1, 1'b0);
        repeat (8) tick();
        hit(1, 1'b1);
        check("hp_after_invuln", int'(boss_hp), 198);

        while (exp_hp > 0) begin
            repeat (8) tick();
            hit(1, 1'b1);
        end
        check("hp_zero", int'(boss_hp), 0);

        // death sequence
        repeat (10) tick();
        probe(610, y_model + 10, 1, "dying_visible");
        hit(1, 1'b0);
        repeat (49) tick();
        check("dead_early", int'(boss_dead), 0);
        check("dying_hold", int'(boss_phase), 3);
        tick();
        check("dead_flag", int'(boss_dead), 1);
        check("dead_phase", int'(boss_phase), 4);
        probe(610, y_model + 10, 0, "dead_hidden");

        // restart
        @(negedge Clk);
        key_R = 1'b1;
        @(negedge Clk);
        check("restart_hp", int'(boss_hp), 200);
        check("restart_phase", int'(boss_phase), 0);
        check("restart_dead", int'(boss_dead), 0);
        check("restart_y", actual_y(), 40);
        key_R = 1'b0;
        repeat (2) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
